// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver:
// hex font, blank pattern and index-width helper.
package seg7_pkg;

  // Active-high gfedcba patterns for nibbles 0..F.
  localparam logic [6:0] FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [6:0] SEG_OFF = 7'h00;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg7_scan_display_hex7_decoder.sv
// Combinational nibble to active-high gfedcba
// segment pattern lookup.
module hex7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = FONT[nib];

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed seven-segment driver with shadow
// registers, leading-zero blanking and dead time.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int DIGITS     = 8,
  parameter int SCAN_DIV   = 50000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  lz_en,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an
);

  localparam int IW = idx_w(DIGITS);
  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] sh_val;
  logic [DIGITS-1:0]   sh_dp;

  logic                slot_end;
  logic [DIGITS-1:0]   blank;
  logic [3:0]          nib;
  logic                blank_cur;
  logic                dp_hi;
  logic [DIGITS-1:0]   an_hi;
  logic [6:0]          font_seg;
  logic [6:0]          seg_hi;

  assign slot_end = (cnt == CW'(SCAN_DIV - 1));

  // Blank a digit when it and everything above it is zero.
  always_comb begin
    logic zr;
    zr    = 1'b1;
    blank = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zr       = zr && (sh_val[4*i +: 4] == 4'h0);
      blank[i] = lz_en && zr && (i != 0);
    end
  end

  always_comb begin
    nib       = '0;
    blank_cur = 1'b0;
    dp_hi     = 1'b0;
    an_hi     = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib       = sh_val[4*i +: 4];
        blank_cur = blank[i];
        dp_hi     = sh_dp[i];
        an_hi[i]  = (cnt != '0);
      end
    end
  end

  hex7_decoder u_dec (
    .nib (nib),
    .seg (font_seg)
  );

  assign seg_hi = blank_cur ? SEG_OFF : font_seg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt    <= '0;
      idx    <= '0;
      sh_val <= '0;
      sh_dp  <= '0;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end)
        idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
      if (load) begin
        sh_val <= value;
        sh_dp  <= dp_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      seg <= SEG_OFF ^ {7{ACTIVE_LOW}};
      dp  <= ACTIVE_LOW;
      an  <= {DIGITS{ACTIVE_LOW}};
    end else begin
      seg <= seg_hi ^ {7{ACTIVE_LOW}};
      dp  <= dp_hi ^ ACTIVE_LOW;
      an  <= an_hi ^ {DIGITS{ACTIVE_LOW}};
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display: arithmetic reference
// model, vector table and hand-written sequences.
module tb_seg7_scan_display;

  localparam int DG = 4;
  localparam int SD = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [15:0]   value = '0;
  logic [3:0]    dp_in = '0;
  logic          load = 1'b0;
  logic          lz_en = 1'b0;

  logic [6:0]    seg_lo, seg_hi;
  logic          dp_lo, dp_hi;
  logic [3:0]    an_lo, an_hi;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  seg7_scan_display #(
    .DIGITS(DG), .SCAN_DIV(SD), .ACTIVE_LOW(1'b0)
  ) u_lo (
    .clk(clk), .reset(reset), .value(value),
    .dp_in(dp_in), .load(load), .lz_en(lz_en),
    .seg(seg_lo), .dp(dp_lo), .an(an_lo)
  );

  seg7_scan_display #(
    .DIGITS(DG), .SCAN_DIV(SD), .ACTIVE_LOW(1'b1)
  ) u_hi (
    .clk(clk), .reset(reset), .value(value),
    .dp_in(dp_in), .load(load), .lz_en(lz_en),
    .seg(seg_hi), .dp(dp_hi), .an(an_hi)
  );

  task automatic check(input string name,
                       input logic [15:0] act,
                       input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Reference model: position in scan derived from edge count.
  logic [6:0]  font [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  int          k = 0;
  int          mc, md;
  logic [15:0] msv = '0;
  logic [3:0]  msd = '0;
  logic [15:0] above;
  logic [6:0]  e_seg = '0;
  logic        e_dp = 1'b0;
  logic [3:0]  e_an = '0;
  bit          armed = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      e_seg = '0; e_dp = 1'b0; e_an = '0;
      k = 0; msv = '0; msd = '0;
    end else begin
      mc    = k % SD;
      md    = (k / SD) % DG;
      above = msv >> (4 * md);
      e_seg = (lz_en && md != 0 && above == 0) ? 7'h00
              : font[above[3:0]];
      e_dp  = msd[md];
      e_an  = (mc == 0) ? 4'h0 : 4'(1 << md);
      k++;
      if (load) begin
        msv = value;
        msd = dp_in;
      end
    end
    armed = 1'b1;
  end

  always @(negedge clk) begin
    if (armed) begin
      check("model seg", {9'd0, seg_lo}, {9'd0, e_seg});
      check("model dp", {15'd0, dp_lo}, {15'd0, e_dp});
      check("model an", {12'd0, an_lo}, {12'd0, e_an});
      check("model seg_n", {9'd0, seg_hi}, {9'd0, ~e_seg});
      check("model dp_n", {15'd0, dp_hi}, {15'd0, ~e_dp});
      check("model an_n", {12'd0, an_hi}, {12'd0, ~e_an});
    end
  end

  typedef struct {
    logic [15:0] val;
    logic [3:0]  dpr;
    logic        lz;
    int          dig;
    logic [6:0]  xseg;
    logic        xdp;
  } vec_t;

  vec_t vecs [15];

  logic [3:0] sw_an  [17];
  logic [6:0] sw_seg [4];

  initial begin
    vecs[0]  = '{16'h0005, 4'b0000, 1'b1, 3, 7'h00, 1'b0};
    vecs[1]  = '{16'h0005, 4'b0000, 1'b1, 2, 7'h00, 1'b0};
    vecs[2]  = '{16'h0005, 4'b0000, 1'b1, 1, 7'h00, 1'b0};
    vecs[3]  = '{16'h0005, 4'b0000, 1'b1, 0, 7'h6D, 1'b0};
    vecs[4]  = '{16'h0000, 4'b0000, 1'b1, 0, 7'h3F, 1'b0};
    vecs[5]  = '{16'h0000, 4'b0000, 1'b1, 1, 7'h00, 1'b0};
    vecs[6]  = '{16'h0500, 4'b0000, 1'b1, 0, 7'h3F, 1'b0};
    vecs[7]  = '{16'h0500, 4'b0000, 1'b1, 1, 7'h3F, 1'b0};
    vecs[8]  = '{16'h0500, 4'b0000, 1'b1, 3, 7'h00, 1'b0};
    vecs[9]  = '{16'h0500, 4'b0000, 1'b1, 2, 7'h6D, 1'b0};
    vecs[10] = '{16'h0001, 4'b0100, 1'b1, 2, 7'h00, 1'b1};
    vecs[11] = '{16'h0001, 4'b0100, 1'b1, 1, 7'h00, 1'b0};
    vecs[12] = '{16'h0001, 4'b0100, 1'b1, 0, 7'h06, 1'b0};
    vecs[13] = '{16'h12AF, 4'b0000, 1'b0, 3, 7'h06, 1'b0};
    vecs[14] = '{16'h0005, 4'b0000, 1'b0, 3, 7'h3F, 1'b0};

    sw_an = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0,
              4'h4, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h8, 4'h0,
              4'h1};
    sw_seg = '{7'h71, 7'h77, 7'h5B, 7'h06};

    // Reset held three cycles, then release.
    reset = 1'b0;
    repeat (3) step();
    check("rst seg_n", {9'd0, seg_hi}, 16'h007F);
    check("rst dp_n", {15'd0, dp_hi}, 16'h0001);
    check("rst an_n", {12'd0, an_hi}, 16'h000F);
    check("rst an", {12'd0, an_lo}, 16'h0000);
    reset = 1'b1;
    step();
    check("rel1 an_n", {12'd0, an_hi}, 16'h000F);
    step();
    check("rel2 an_n", {12'd0, an_hi}, 16'h000E);

    // Sweep of 0x12AF from a fresh reset.
    reset = 1'b0;
    step();
    reset = 1'b1; value = 16'h12AF; load = 1'b1; lz_en = 1'b0;
    dp_in = 4'b0000;
    step();
    load = 1'b0;
    for (int j = 0; j < 17; j++) begin
      step();
      check("sweep an", {12'd0, an_lo}, {12'd0, sw_an[j]});
      if (sw_an[j] != 4'h0)
        check("sweep seg", {9'd0, seg_lo},
              {9'd0, sw_seg[(j / 4) % 4]});
    end

    // Table vectors: load, then inspect the named digit.
    foreach (vecs[v]) begin
      int n;
      value = vecs[v].val; dp_in = vecs[v].dpr;
      lz_en = vecs[v].lz; load = 1'b1;
      step();
      load = 1'b0;
      n = 0;
      do begin
        step();
        n++;
      end while (e_an != 4'(1 << vecs[v].dig) && n < 40);
      check("vec wait", {15'd0, n >= 40}, 16'h0000);
      check("vec an", {12'd0, an_lo}, {12'd0, 4'(1 << vecs[v].dig)});
      check("vec seg", {9'd0, seg_lo}, {9'd0, vecs[v].xseg});
      check("vec dp", {15'd0, dp_lo}, {15'd0, vecs[v].xdp});
    end

    // Back-to-back loads inside digit 0's slot.
    lz_en = 1'b0; dp_in = '0;
    reset = 1'b0;
    step();
    reset = 1'b1; value = 16'h0003; load = 1'b1;
    step();
    value = 16'h0008;
    step();
    load = 1'b0;
    check("ld1 seg", {9'd0, seg_lo}, 16'h004F);
    check("ld1 an", {12'd0, an_lo}, 16'h0001);
    step();
    check("ld2 seg", {9'd0, seg_lo}, 16'h007F);
    check("ld2 an", {12'd0, an_lo}, 16'h0001);

    // Reset pulse during digit 2 of a sweep.
    value = 16'h12AF; load = 1'b1;
    step();
    load = 1'b0;
    begin
      int n;
      n = 0;
      while (e_an != 4'h4 && n < 40) begin
        step();
        n++;
      end
      check("mid wait", {15'd0, n >= 40}, 16'h0000);
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("mid an", {12'd0, an_lo}, 16'h0000);
    check("mid seg_n", {9'd0, seg_hi}, 16'h007F);
    check("mid an_n", {12'd0, an_hi}, 16'h000F);
    step();
    check("mid r1 an", {12'd0, an_lo}, 16'h0000);
    step();
    check("mid r2 an", {12'd0, an_lo}, 16'h0001);
    check("mid r2 seg", {9'd0, seg_lo}, 16'h003F);

    // Random traffic against the model.
    for (int r = 0; r < 800; r++) begin
      value = 16'($urandom);
      if ($urandom_range(0, 1) == 0) value = value & 16'h00FF;
      dp_in = 4'($urandom);
      lz_en = 1'($urandom);
      load  = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 63) != 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
